hazard_controller: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage MIPS core. It drives the stall and flush controls of the fetch, decode and execute pipeline registers, and the forwarding selects for the decode and execute stages. It also owns a multi-cycle multiply/divide (MDU) busy sequencer and saturating stall/flush performance counters. It sits beside the datapath and is evaluated every cycle.

---
 rtl/mips_hazard_pkg.sv | 9 +
 rtl/hazard_controller_if.sv | 26 ++
 rtl/mdu_sequencer.sv | 42 ++++
 rtl/hazard_controller.sv | 48 ++++
 tb/tb_hazard_controller.sv | 128 ++++++++++++
 5 files changed

// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared widths, forward selects, MDU states and helper for hazard control
package mips_hazard_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_e_t;
  typedef enum logic {IDLE, BUSY} mdu_state_t;
  function automatic logic hit(input logic we, input logic [REG_ADDR_W-1:0] wr, input logic [REG_ADDR_W-1:0] src);
    return we && wr != '0 && wr == src;
  endfunction
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: datapath-to-hazard-controller signal bundle
interface hazard_controller_if #(parameter int PERF_W = 32);
  import mips_hazard_pkg::*;
  logic [REG_ADDR_W-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic branch_d, pc_src_d, jump_d, mdu_use_d, mdu_start_e, mdu_div_e, perf_clr;
  logic stall_f, stall_d, stall_e, flush_d, flush_e;
  logic forward_a_d, forward_b_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic mdu_busy, mdu_done;
  logic [PERF_W-1:0] stall_count, flush_count;
  modport master(
    output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
    output reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
    output branch_d, pc_src_d, jump_d, mdu_use_d, mdu_start_e, mdu_div_e, perf_clr,
    input stall_f, stall_d, stall_e, flush_d, flush_e, forward_a_d, forward_b_d,
    input forward_a_e, forward_b_e, mdu_busy, mdu_done, stall_count, flush_count
  );
  modport slave(
    input rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
    input reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
    input branch_d, pc_src_d, jump_d, mdu_use_d, mdu_start_e, mdu_div_e, perf_clr,
    output stall_f, stall_d, stall_e, flush_d, flush_e, forward_a_d, forward_b_d,
    output forward_a_e, forward_b_e, mdu_busy, mdu_done, stall_count, flush_count
  );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multiply/divide busy sequencer with one-cycle completion pulse
module mdu_sequencer import mips_hazard_pkg::*; #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic div,
  output logic busy,
  output logic done
);
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
  mdu_state_t state, state_n;
  logic [5:0] cnt, cnt_n;
  logic done_n;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      done <= done_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    done_n = 1'b0;
    if (state == IDLE && start) begin
      state_n = BUSY;
      cnt_n = div ? DIV_LOAD : MUL_LOAD;
    end else if (state == BUSY) begin
      cnt_n = cnt != '0 ? cnt - 6'd1 : cnt;
      state_n = cnt != '0 ? BUSY : IDLE;
      done_n = cnt == '0;
    end
  end
  assign busy = state == BUSY;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward control, MDU sequencing and saturating perf counters
module hazard_controller import mips_hazard_pkg::*; #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int PERF_W = 32
) (
  input logic clk,
  input logic clr,
  hazard_controller_if.slave h
);
  logic lw_stall, branch_stall, mdu_stall, stall, busy;
  logic [PERF_W-1:0] stall_count, flush_count;
  mdu_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_mdu (
    .clk(clk), .clr(clr), .start(h.mdu_start_e), .div(h.mdu_div_e), .busy(busy), .done(h.mdu_done)
  );
  always_comb begin
    h.forward_a_e = hit(h.reg_write_m, h.write_reg_m, h.rs_e) ? FWD_MEM :
                    hit(h.reg_write_w, h.write_reg_w, h.rs_e) ? FWD_WB : FWD_NONE;
    h.forward_b_e = hit(h.reg_write_m, h.write_reg_m, h.rt_e) ? FWD_MEM :
                    hit(h.reg_write_w, h.write_reg_w, h.rt_e) ? FWD_WB : FWD_NONE;
    h.forward_a_d = hit(h.reg_write_m, h.write_reg_m, h.rs_d);
    h.forward_b_d = hit(h.reg_write_m, h.write_reg_m, h.rt_d);
    lw_stall = h.mem_to_reg_e && h.rt_e != '0 && (h.rt_e == h.rs_d || h.rt_e == h.rt_d);
    branch_stall = h.branch_d && (hit(h.reg_write_e, h.write_reg_e, h.rs_d) || hit(h.reg_write_e, h.write_reg_e, h.rt_d) ||
                                  hit(h.mem_to_reg_m, h.write_reg_m, h.rs_d) || hit(h.mem_to_reg_m, h.write_reg_m, h.rt_d));
    mdu_stall = h.mdu_use_d && (busy || h.mdu_start_e);
    stall = lw_stall || branch_stall || mdu_stall;
    h.stall_f = stall;
    h.stall_d = stall;
    h.flush_e = stall;
    h.stall_e = 1'b0;
    h.flush_d = (h.pc_src_d || h.jump_d) && !stall;
    h.mdu_busy = busy;
    h.stall_count = stall_count;
    h.flush_count = flush_count;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (h.perf_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (h.flush_d && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed stimulus with queued expectations checked by a negedge monitor
module tb_hazard_controller;
  typedef struct {string name; logic [28:0] val; logic [28:0] mask;} exp_t;
  logic clk = 1'b0, clr;
  int total = 0, bad = 0;
  exp_t q[$];
  logic [28:0] act;
  hazard_controller_if #(.PERF_W(8)) h();
  hazard_controller #(.MUL_CYCLES(4), .DIV_CYCLES(32), .PERF_W(8)) dut(.clk(clk), .clr(clr), .h(h));
  always #5 clk = ~clk;
  assign act = {h.stall_f, h.stall_d, h.stall_e, h.flush_d, h.flush_e, h.forward_a_d, h.forward_b_d,
                h.forward_a_e, h.forward_b_e, h.mdu_busy, h.mdu_done, h.stall_count, h.flush_count};
  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        bad++;
        $display("FAIL %s: got %h want %h (mask %h) at %0t", e.name, act & e.mask, e.val & e.mask, e.mask, $time);
      end
    end
  always @(posedge clk)
    if (!clr && h.mdu_start_e && h.mdu_busy) begin
      bad++;
      $display("FAIL mdu_start_while_busy: got start=1 busy=1 want no start while busy at %0t", $time);
    end
  task automatic push(input string n, input logic [28:0] v, input logic [28:0] m);
    q.push_back('{n, v, m});
  endtask
  task automatic exp_stall(input string n, input logic s, input logic fd);
    push(n, {s, s, 1'b0, fd, s, 24'b0}, {5'h1f, 24'b0});
  endtask
  task automatic exp_fwd(input string n, input logic fad, input logic fbd, input logic [1:0] fae, input logic [1:0] fbe);
    push(n, {5'b0, fad, fbd, fae, fbe, 18'b0}, {5'b0, 6'h3f, 18'b0});
  endtask
  task automatic exp_mdu(input string n, input logic b, input logic d);
    push(n, {11'b0, b, d, 16'b0}, {11'b0, 2'b11, 16'b0});
  endtask
  task automatic exp_cnt(input string n, input logic [7:0] sc, input logic [7:0] fc);
    push(n, {13'b0, sc, fc}, {13'b0, 16'hffff});
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {h.rs_d, h.rt_d, h.rs_e, h.rt_e, h.write_reg_e, h.write_reg_m, h.write_reg_w} = '0;
    {h.reg_write_e, h.reg_write_m, h.reg_write_w, h.mem_to_reg_e, h.mem_to_reg_m} = '0;
    {h.branch_d, h.pc_src_d, h.jump_d, h.mdu_use_d, h.mdu_start_e, h.mdu_div_e, h.perf_clr} = '0;
  endtask
  task automatic lw_hazard();
    h.mem_to_reg_e = 1'b1;
    h.rt_e = 5'd8;
    h.rs_d = 5'd8;
  endtask
  initial begin
    clr = 1'b1;
    idle();
    exp_stall("rst_stall", 0, 0);
    exp_mdu("rst_mdu", 0, 0);
    exp_cnt("rst_cnt", 0, 0);
    cyc(); clr = 1'b0;
    cyc(); idle(); h.rs_e = 5; h.write_reg_m = 5; h.write_reg_w = 5; h.reg_write_m = 1; h.reg_write_w = 1;
    exp_fwd("fwd_mem_prio", 0, 0, 2'b10, 2'b00);
    cyc(); h.reg_write_m = 0; exp_fwd("fwd_wb", 0, 0, 2'b01, 2'b00);
    cyc(); h.write_reg_w = 0; exp_fwd("fwd_wb_r0", 0, 0, 2'b00, 2'b00);
    cyc(); idle(); h.rs_e = 5; h.rt_e = 7; h.write_reg_m = 5; h.reg_write_m = 1; h.write_reg_w = 7; h.reg_write_w = 1;
    exp_fwd("fwd_mixed", 0, 0, 2'b10, 2'b01);
    cyc(); idle(); h.rs_d = 9; h.rt_d = 9; h.write_reg_m = 9; h.reg_write_m = 1;
    exp_fwd("fwd_d_both", 1, 1, 2'b00, 2'b00); exp_stall("fwd_d_nostall", 0, 0);
    cyc(); idle(); h.reg_write_m = 1; h.reg_write_w = 1; exp_fwd("fwd_r0", 0, 0, 2'b00, 2'b00);
    cyc(); idle(); h.mem_to_reg_e = 1; exp_stall("lw_r0", 0, 0);
    cyc(); idle(); lw_hazard(); exp_stall("lw_stall", 1, 0);
    cyc(); idle(); exp_stall("lw_release", 0, 0); exp_cnt("lw_count", 1, 0);
    cyc(); idle(); h.branch_d = 1; h.reg_write_e = 1; h.write_reg_e = 3; h.rt_d = 3; exp_stall("br_stall_e", 1, 0);
    cyc(); idle(); h.branch_d = 1; h.rt_d = 3; h.write_reg_m = 3; h.reg_write_m = 1;
    exp_stall("br_release", 0, 0); exp_fwd("br_fwd", 0, 1, 2'b00, 2'b00);
    cyc(); idle(); h.branch_d = 1; h.rs_d = 3; h.write_reg_m = 3; h.mem_to_reg_m = 1; exp_stall("br_stall_m", 1, 0);
    cyc(); idle(); h.branch_d = 1; h.reg_write_e = 1; h.mem_to_reg_m = 1; exp_stall("br_r0", 0, 0);
    cyc(); idle(); exp_cnt("br_count", 3, 0);
    cyc(); idle(); h.jump_d = 1; lw_hazard(); exp_stall("jmp_in_stall", 1, 0);
    cyc(); idle(); h.jump_d = 1; exp_stall("jmp_taken", 0, 1);
    cyc(); idle(); h.pc_src_d = 1; exp_stall("br_taken", 0, 1);
    cyc(); idle(); exp_cnt("jmp_count", 4, 2);
    cyc(); idle(); h.mdu_start_e = 1; h.mdu_div_e = 1; h.mdu_use_d = 1;
    exp_stall("div_start_stall", 1, 0); exp_mdu("div_start", 0, 0);
    for (int i = 1; i <= 32; i++) begin
      cyc(); idle(); h.mdu_use_d = 1; exp_stall("div_wait", 1, 0); exp_mdu("div_busy", 1, 0);
    end
    cyc(); idle(); h.mdu_use_d = 1; exp_stall("div_release", 0, 0); exp_mdu("div_done", 0, 1);
    cyc(); idle(); exp_mdu("div_after", 0, 0); exp_cnt("div_count", 37, 2);
    cyc(); idle(); h.mdu_start_e = 1; exp_stall("mul_start", 0, 0); exp_mdu("mul_start", 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(); idle(); h.mdu_use_d = 1; exp_stall("mul_wait", 1, 0); exp_mdu("mul_busy", 1, 0);
    end
    cyc(); idle(); h.mdu_use_d = 1; exp_stall("mul_release", 0, 0); exp_mdu("mul_done", 0, 1);
    cyc(); idle(); exp_mdu("mul_after", 0, 0); exp_cnt("mul_count", 41, 2);
    cyc(); idle(); h.mdu_start_e = 1; h.mdu_div_e = 1;
    cyc(); idle(); exp_mdu("clr_pre", 1, 0);
    repeat (3) cyc();
    cyc(); #2 clr = 1'b1; h.mdu_use_d = 1;
    exp_mdu("clr_abort", 0, 0); exp_cnt("clr_cnt", 0, 0); exp_stall("clr_comb", 0, 0);
    cyc(); clr = 1'b0; idle();
    for (int i = 0; i < 40; i++) begin
      cyc(); exp_mdu("clr_no_done", 0, 0);
    end
    cyc(); idle(); lw_hazard();
    repeat (254) cyc();
    cyc(); idle(); exp_cnt("sat_255", 255, 0);
    cyc(); lw_hazard();
    repeat (4) cyc();
    cyc(); idle(); exp_cnt("sat_hold", 255, 0);
    cyc(); lw_hazard(); h.perf_clr = 1;
    cyc(); idle(); exp_cnt("perf_clr_stall", 0, 0);
    cyc(); h.jump_d = 1;
    repeat (299) cyc();
    cyc(); idle(); exp_cnt("fsat_255", 0, 255);
    cyc(); h.jump_d = 1; h.perf_clr = 1;
    cyc(); idle(); exp_cnt("perf_clr_flush", 0, 0);
    cyc();
    cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
